// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bus of the instruction-memory loader.
// The master modport is the loader side; the slave modport is the stream source / memory side.
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );

  modport slave (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Loads big-endian 32-bit words from a byte stream into instruction memory, holding the core in reset meanwhile.
// Optional trailer checksum byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int ADDR_W      = 8,
  parameter int BASE_ADDR   = 0,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load_req,
  imem_loader_if.master  bus,
  output logic           cpu_reset,
  output logic           load_done,
  output logic           load_err
);

  localparam int CW = ADDR_W + 1;
  localparam int TW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
    ST_CKSUM,
`endif
    ST_DONE,
    ST_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     idx_q, idx_d;
  logic [1:0]        byte_q, byte_d;
  logic [31:0]       word_q, word_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [7:0]        csum_q, csum_d;
  logic              rx_ready_q, rx_ready_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              load_done_q, load_done_d;
  logic              load_err_q, load_err_d;
  logic              accept_s;
  logic              listening_s;
  logic              timeout_s;

  assign accept_s  = bus.rx_valid & rx_ready_q;
  assign timeout_s = (timer_q == TW'(TIMEOUT_CYC - 1)) & ~accept_s;

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    byte_d       = byte_q;
    word_d       = word_q;
    timer_d      = timer_q;
    csum_d       = csum_q;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    listening_s  = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (load_req) begin
          state_d = ST_HDR;
          idx_d   = {CW{1'b0}};
          byte_d  = 2'd0;
          timer_d = {TW{1'b0}};
          csum_d  = 8'h00;
        end else begin
          state_d = state_q;
        end
      end
      ST_HDR: begin
        listening_s = 1'b1;
        if (accept_s) begin
          // A header of zero stands for a full memory image.
          cnt_d   = (bus.rx_data == 8'h00) ? (CW'(1) << ADDR_W) : CW'(bus.rx_data);
          csum_d  = csum_q ^ bus.rx_data;
          state_d = ST_DATA;
        end else if (timeout_s) begin
          state_d = ST_ERR;
        end else begin
          state_d = state_q;
        end
      end
      ST_DATA: begin
        listening_s = 1'b1;
        if (accept_s) begin
          word_d = {word_q[23:0], bus.rx_data};
          csum_d = csum_q ^ bus.rx_data;
          byte_d = byte_q + 2'd1;
          if (byte_q == 2'd3) begin
            state_d      = ST_WRITE;
            imem_addr_d  = ADDR_W'(BASE_ADDR) + idx_q[ADDR_W-1:0];
            imem_wdata_d = {word_q[23:0], bus.rx_data};
          end else begin
            state_d = ST_DATA;
          end
        end else if (timeout_s) begin
          state_d = ST_ERR;
        end else begin
          state_d = state_q;
        end
      end
      ST_WRITE: begin
        idx_d = idx_q + CW'(1);
        if ((idx_q + CW'(1)) == cnt_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = ST_CKSUM;
`else
          state_d = ST_DONE;
`endif
        end else begin
          state_d = ST_DATA;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CKSUM: begin
        listening_s = 1'b1;
        if (accept_s) begin
          state_d = (bus.rx_data == csum_q) ? ST_DONE : ST_ERR;
        end else if (timeout_s) begin
          state_d = ST_ERR;
        end else begin
          state_d = state_q;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Idle-gap timer runs only while waiting on the stream.
    if (listening_s) begin
      if (accept_s) begin
        timer_d = {TW{1'b0}};
      end else begin
        timer_d = timer_q + TW'(1);
      end
    end else begin
      timer_d = timer_d;
    end

    rx_ready_d  = (state_d == ST_HDR) || (state_d == ST_DATA)
`ifdef IMEM_LOADER_CHECKSUM_EN
                  || (state_d == ST_CKSUM)
`endif
                  ;
    imem_we_d   = (state_d == ST_WRITE);
    cpu_reset_d = (state_d != ST_DONE);
    load_done_d = (state_d == ST_DONE);
    load_err_d  = (state_d == ST_ERR);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= {CW{1'b0}};
      idx_q        <= {CW{1'b0}};
      byte_q       <= 2'd0;
      word_q       <= 32'h0000_0000;
      timer_q      <= {TW{1'b0}};
      csum_q       <= 8'h00;
      rx_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= ADDR_W'(BASE_ADDR);
      imem_wdata_q <= 32'h0000_0000;
      cpu_reset_q  <= 1'b1;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      byte_q       <= byte_d;
      word_q       <= word_d;
      timer_q      <= timer_d;
      csum_q       <= csum_d;
      rx_ready_q   <= rx_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_reset_q  <= cpu_reset_d;
      load_done_q  <= load_done_d;
      load_err_q   <= load_err_d;
    end
  end

  assign bus.rx_ready   = rx_ready_q;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.imem_wdata = imem_wdata_q;
  assign cpu_reset      = cpu_reset_q;
  assign load_done      = load_done_q;
  assign load_err       = load_err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected memory writes go into a scoreboard queue and are popped on imem_we.
// Built with BASE_ADDR=0xFE and TIMEOUT_CYC=16 so address wrap and timeout are reachable quickly.
module tb_imem_loader;
  localparam int AW   = 8;
  localparam int BASE = 254;
  localparam int TMO  = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic load_req = 1'b0;
  logic cpu_reset, load_done, load_err;

  imem_loader_if #(.ADDR_W(AW)) bus ();

  imem_loader #(.ADDR_W(AW), .BASE_ADDR(BASE), .TIMEOUT_CYC(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .load_req  (load_req),
    .bus       (bus),
    .cpu_reset (cpu_reset),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int wr_cnt = 0;
  logic [39:0] exp_q[$];
  logic [7:0]  pl [0:1023];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        check("wr_unexpected", 32'(exp_q.size()), 32'd1);
      end else begin
        logic [39:0] e;
        e = exp_q.pop_front();
        check("wr_addr", {24'h0, bus.imem_addr}, {24'h0, e[39:32]});
        check("wr_data", bus.imem_wdata, e[31:0]);
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_rx_ready"}, {31'h0, bus.rx_ready}, 32'd0);
    check({tag, "_we"}, {31'h0, bus.imem_we}, 32'd0);
    check({tag, "_addr"}, {24'h0, bus.imem_addr}, 32'(BASE));
    check({tag, "_wdata"}, bus.imem_wdata, 32'h0);
    check({tag, "_cpu_reset"}, {31'h0, cpu_reset}, 32'd1);
    check({tag, "_done"}, {31'h0, load_done}, 32'd0);
    check({tag, "_err"}, {31'h0, load_err}, 32'd0);
  endtask

  // Presents one byte and returns at the falling edge after it was accepted.
  task automatic send_byte(input logic [7:0] b);
    int n;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    n = 0;
    while (bus.rx_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("send_timeout", 32'(n), 32'd0);
    @(negedge clk);
  endtask

  task automatic pulse_load;
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic run_load(input int nw, input bit hold, input bit bad_trl);
    logic [7:0]  cs;
    logic [31:0] w;
    int n;
    pulse_load();
    cs = 8'(nw);
    send_byte(8'(nw));
    for (int i = 0; i < nw; i++) begin
      w = {pl[4*i], pl[4*i+1], pl[4*i+2], pl[4*i+3]};
      exp_q.push_back({8'(BASE + i), w});
      for (int b = 0; b < 4; b++) begin
        send_byte(pl[4*i+b]);
        cs = cs ^ pl[4*i+b];
        if (!hold) begin
          bus.rx_valid = 1'b0;
          @(negedge clk);
        end
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(bad_trl ? (cs ^ 8'h01) : cs);
`else
    if (bad_trl) cs = ~cs;
`endif
    bus.rx_valid = 1'b0;
    n = 0;
    while (!(load_done === 1'b1 || load_err === 1'b1) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("load_end_timeout", 32'(n), 32'd0);
  endtask

  initial begin
    int k;
    int w0;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    reset = 1'b0;
    @(negedge clk);

    // T2: two fixed words, written at BASE and BASE+1.
    {pl[0], pl[1], pl[2], pl[3]} = 32'h2008_0005;
    {pl[4], pl[5], pl[6], pl[7]} = 32'hAC08_0004;
    w0 = wr_cnt;
    run_load(2, 1'b0, 1'b0);
    check("t2_done", {31'h0, load_done}, 32'd1);
    check("t2_cpu_reset", {31'h0, cpu_reset}, 32'd0);
    check("t2_err", {31'h0, load_err}, 32'd0);
    check("t2_writes", 32'(wr_cnt - w0), 32'd2);
    check("t2_sb_empty", 32'(exp_q.size()), 32'd0);
    bus.rx_valid = 1'b1;
    @(negedge clk);
    check("done_rx_ready", {31'h0, bus.rx_ready}, 32'd0);
    bus.rx_valid = 1'b0;

    // T3: rx_valid held through every write cycle.
    for (int i = 0; i < 24; i++) pl[i] = 8'($urandom);
    w0 = wr_cnt;
    run_load(6, 1'b1, 1'b0);
    check("t3_done", {31'h0, load_done}, 32'd1);
    check("t3_writes", 32'(wr_cnt - w0), 32'd6);
    check("t3_sb_empty", 32'(exp_q.size()), 32'd0);

    // T1: asynchronous reset in the middle of a word.
    pulse_load();
    check("t1_cpu_reset_hdr", {31'h0, cpu_reset}, 32'd1);
    send_byte(8'h02);
    send_byte(8'hAA);
    send_byte(8'hBB);
    bus.rx_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("t1");
    reset = 1'b0;
    @(negedge clk);
    {pl[0], pl[1], pl[2], pl[3]} = 32'h1234_5678;
    w0 = wr_cnt;
    run_load(1, 1'b0, 1'b0);
    check("t1_fresh_done", {31'h0, load_done}, 32'd1);
    check("t1_fresh_writes", 32'(wr_cnt - w0), 32'd1);

    // T4: three words wrap FE, FF, 00; then header 0 loads 256 words.
    for (int i = 0; i < 12; i++) pl[i] = 8'($urandom);
    run_load(3, 1'b0, 1'b0);
    check("t4_wrap_done", {31'h0, load_done}, 32'd1);
    check("t4_wrap_sb", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < 1024; i++) pl[i] = 8'($urandom);
    w0 = wr_cnt;
    run_load(256, 1'b1, 1'b0);
    check("t4_n0_writes", 32'(wr_cnt - w0), 32'd256);
    check("t4_n0_done", {31'h0, load_done}, 32'd1);
    check("t4_n0_sb", 32'(exp_q.size()), 32'd0);

    // T5: stream stalls after two payload bytes.
    w0 = wr_cnt;
    pulse_load();
    send_byte(8'h02);
    send_byte(8'h11);
    send_byte(8'h22);
    bus.rx_valid = 1'b0;
    k = 0;
    while (load_err !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("t5_idle_cycles", 32'(k), 32'(TMO));
    check("t5_err", {31'h0, load_err}, 32'd1);
    check("t5_cpu_reset", {31'h0, cpu_reset}, 32'd1);
    check("t5_done", {31'h0, load_done}, 32'd0);
    check("t5_no_write", 32'(wr_cnt - w0), 32'd0);
    check("t5_rx_ready", {31'h0, bus.rx_ready}, 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // T6: trailer must equal XOR of header and payload.
    {pl[0], pl[1], pl[2], pl[3]} = 32'h0000_0001;
    run_load(1, 1'b0, 1'b0);
    check("t6_good_done", {31'h0, load_done}, 32'd1);
    check("t6_good_cpu_reset", {31'h0, cpu_reset}, 32'd0);
    w0 = wr_cnt;
    run_load(1, 1'b0, 1'b1);
    check("t6_bad_err", {31'h0, load_err}, 32'd1);
    check("t6_bad_cpu_reset", {31'h0, cpu_reset}, 32'd1);
    check("t6_bad_written", 32'(wr_cnt - w0), 32'd1);
`endif

    repeat (3) @(negedge clk);
    check("final_sb_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
